// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if
// Groups the request-side handshake and the uart_tx-side signals of the
// transmit scheduler.
//   req_valid[2:0]  per-source byte valid (bit i = source i)
//   req_data[23:0]  per-source byte, source i on bits [8i+7:8i]
//   req_ready[2:0]  per-source slot empty
//   tx_data[7:0]    byte to uart_tx
//   tx_send         one-cycle send strobe to uart_tx
//   tx_busy         uart_tx busy flag
//   grant_id[1:0]   source currently being transmitted
//   active          transmission in progress
//   timeout_err     pulse when tx_busy fails to rise after a send
// Modports: master = byte sources plus uart_tx side, slave = scheduler.
interface uart_tx_scheduler_if;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_data, tx_send, grant_id, active, timeout_err
  );

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_data, tx_send, grant_id, active, timeout_err
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one uart_tx transmitter among three byte sources (game events,
// periodic status, RX echo/debug). Each source fills a one-byte holding slot
// over valid/ready; an arbiter sequences pending slots onto uart_tx through a
// tx_data/tx_send/tx_busy handshake and watches for a missing busy response.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    uart_tx_scheduler_if.slave (request handshake + uart_tx side)
//
// Parameters:
//   BUSY_TIMEOUT  cycles to wait for tx_busy to rise after tx_send (2..255)
//
// Build option:
//   UART_TX_SCHED_STRICT_PRIO_EN  when defined, the lowest-index pending
//   source always wins (source 0 highest); otherwise round-robin starting
//   after the last granted source.
module uart_tx_scheduler #(
  parameter int BUSY_TIMEOUT = 16
) (
  input logic          clk,
  input logic          reset,
  uart_tx_scheduler_if.slave bus
);

  // Counter compare value: timeout fires on the edge where the count,
  // started at 0 on the grant edge, has reached BUSY_TIMEOUT-1.
  localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_WAIT = 2'd1,
    DONE_WAIT = 2'd2
  } state_t;

  state_t      state_reg;
  logic [2:0]  pending_reg;
  logic [1:0]  last_grant_reg;
  logic [7:0]  count_reg;
  logic [7:0]  tx_data_reg;
  logic        tx_send_reg;
  logic [1:0]  grant_reg;
  logic        active_reg;
  logic        timeout_err_reg;
  logic [7:0]  hold_reg [3];

  logic [2:0]  accept;
  logic        sel_valid;
  logic [1:0]  sel;
  logic [7:0]  sel_byte;

  // Holding slots. A slot only loads while empty, so a byte can never be
  // overwritten before it has been sent or dropped.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      assign accept[gi] = bus.req_valid[gi] & ~pending_reg[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hold_reg[gi] <= '0;
        end else if (accept[gi]) begin
          hold_reg[gi] <= bus.req_data[8*gi +: 8];
        end
      end
    end
  endgenerate

`ifndef UART_TX_SCHED_STRICT_PRIO_EN
  // Scan order last+1, last+2, last (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] pend,
                                         input logic [1:0] last);
    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;
    case (last)
      2'd0: begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd1: begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
    endcase
    if (pend[first]) begin
      rr_pick = first;
    end else if (pend[second]) begin
      rr_pick = second;
    end else begin
      rr_pick = third;
    end
  endfunction
`endif

  always_comb begin
    sel_valid = |pending_reg;
`ifdef UART_TX_SCHED_STRICT_PRIO_EN
    if (pending_reg[0]) begin
      sel = 2'd0;
    end else if (pending_reg[1]) begin
      sel = 2'd1;
    end else begin
      sel = 2'd2;
    end
`else
    sel = rr_pick(pending_reg, last_grant_reg);
`endif
  end

  always_comb begin
    case (sel)
      2'd0:    sel_byte = hold_reg[0];
      2'd1:    sel_byte = hold_reg[1];
      default: sel_byte = hold_reg[2];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      pending_reg     <= 3'b000;
      last_grant_reg  <= 2'd2;
      count_reg       <= 8'd0;
      tx_data_reg     <= 8'd0;
      tx_send_reg     <= 1'b0;
      grant_reg       <= 2'd0;
      active_reg      <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      tx_send_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;

      // New bytes land here; the clears below can only touch the slot being
      // transmitted, which is not ready, so both never hit the same bit.
      for (int i = 0; i < 3; i++) begin
        if (accept[i]) begin
          pending_reg[i] <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (sel_valid && !bus.tx_busy) begin
            tx_data_reg <= sel_byte;
            tx_send_reg <= 1'b1;
            grant_reg   <= sel;
            active_reg  <= 1'b1;
            count_reg   <= 8'd0;
            state_reg   <= SEND_WAIT;
          end
        end

        SEND_WAIT: begin
          if (bus.tx_busy) begin
            state_reg <= DONE_WAIT;
          end else if (count_reg == TIMEOUT_LAST) begin
            // uart_tx never acknowledged: drop the byte and move on.
            timeout_err_reg        <= 1'b1;
            pending_reg[grant_reg] <= 1'b0;
            last_grant_reg         <= grant_reg;
            active_reg             <= 1'b0;
            state_reg              <= IDLE;
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end

        DONE_WAIT: begin
          if (!bus.tx_busy) begin
            pending_reg[grant_reg] <= 1'b0;
            last_grant_reg         <= grant_reg;
            active_reg             <= 1'b0;
            state_reg              <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = ~pending_reg;
  assign bus.tx_data     = tx_data_reg;
  assign bus.tx_send     = tx_send_reg;
  assign bus.grant_id    = grant_reg;
  assign bus.active      = active_reg;
  assign bus.timeout_err = timeout_err_reg;

endmodule
